// File: rtl/ife_pkg.sv
// Shared types for the core-to-IFE result return path.
// One result_t is one register writeback from one core.
package ife_pkg;

  localparam int BLOCK_ID_W = 8;
  localparam int REG_IDX_W  = 5;
  localparam int DATA_W     = 64;
  localparam int CORE_IDX_W = 4;

  typedef struct packed {
    logic [CORE_IDX_W-1:0] core;
    logic [BLOCK_ID_W-1:0] id;
    logic [REG_IDX_W-1:0]  rd;
    logic [DATA_W-1:0]     data;
    logic                  last;
  } result_t;

  // x0 is hardwired zero, so its writeback value is never meaningful
  function automatic logic [DATA_W-1:0] wb_data(
    input logic [REG_IDX_W-1:0] rd,
    input logic [DATA_W-1:0]    data
  );
    return (rd == '0) ? '0 : data;
  endfunction

endpackage

// File: rtl/core_result_collector_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or
// after ptr, searching upward modulo N.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = $clog2(N)'(c);
      end
    end
  end

endmodule

// File: rtl/core_result_collector.sv
// Collects core writeback results round-robin into a FIFO,
// drains them to the IFE and pulses commit per finished block.
module core_result_collector
  import ife_pkg::*;
#(
  parameter int NUM_CORES = 3,
  parameter int DEPTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CORES-1:0]                core_res_valid,
  output logic [NUM_CORES-1:0]                core_res_ready,
  input  logic [NUM_CORES-1:0][BLOCK_ID_W-1:0] core_res_id,
  input  logic [NUM_CORES-1:0][REG_IDX_W-1:0] core_res_rd,
  input  logic [NUM_CORES-1:0][DATA_W-1:0]    core_res_data,
  input  logic [NUM_CORES-1:0]                core_res_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(NUM_CORES)-1:0]        out_core,
  output logic [BLOCK_ID_W-1:0]               out_id,
  output logic [REG_IDX_W-1:0]                out_rd,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_last,
  output logic                                commit_valid,
  output logic [BLOCK_ID_W-1:0]               commit_id,
  output logic [$clog2(DEPTH):0]              fifo_count,
  output logic [15:0]                         blocks_committed
);

  localparam int CW = $clog2(NUM_CORES);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [CW-1:0]        rr_ptr;
  logic [NUM_CORES-1:0] grant;
  logic [CW-1:0]        grant_idx;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  result_t              wr_ent;
  result_t              head;
  result_t              mem [DEPTH];

  rr_arbiter #(
    .N(NUM_CORES)
  ) u_arb (
    .req      (core_res_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // No push bypass: a full FIFO refuses even when popping
  assign full = (fifo_count == NW'(DEPTH));
  assign core_res_ready =
    grant & {NUM_CORES{~full & rst}};
  assign push = |(core_res_valid & core_res_ready);
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ent      = '0;
    wr_ent.core = CORE_IDX_W'(grant_idx);
    wr_ent.id   = core_res_id[grant_idx];
    wr_ent.rd   = core_res_rd[grant_idx];
    wr_ent.data = wb_data(core_res_rd[grant_idx],
                          core_res_data[grant_idx]);
    wr_ent.last = core_res_last[grant_idx];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rr_ptr     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (grant_idx == CW'(NUM_CORES - 1))
                  ? '0 : grant_idx + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_count != '0);
  assign out_core  = CW'(head.core);
  assign out_id    = head.id;
  assign out_rd    = head.rd;
  assign out_data  = head.data;
  assign out_last  = head.last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid     <= 1'b0;
      commit_id        <= '0;
      blocks_committed <= '0;
    end else begin
      commit_valid <= pop & head.last;
      if (pop & head.last) begin
        commit_id        <= head.id;
        blocks_committed <= blocks_committed + 16'd1;
      end
    end
  end

endmodule
